// File: rtl/engine_memory_arbiter_if.sv
// Bundle of the engine-side request/response bus and the shared instruction-memory
// port. The slave modport is the arbiter's view; the master modport is the view of
// the engine array together with the memory.
interface engine_memory_arbiter_if #(
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int ENGINE_ID_BITS    = 2
);
  localparam int N = 2 ** ENGINE_ID_BITS;

  logic [N-1:0]                   req_valid;
  logic [N*MEMORY_ADDR_WIDTH-1:0] req_addr;
  logic [N-1:0]                   req_ready;
  logic [MEMORY_WIDTH-1:0]        req_data;
  logic [MEMORY_ADDR_WIDTH-1:0]   bcast_addr;
  logic                           bcast_valid;
  logic                           mem_valid;
  logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr;
  logic                           mem_ready;
  logic [MEMORY_WIDTH-1:0]        mem_data;
  logic [MEMORY_ADDR_WIDTH-1:0]   mem_broadcast_addr;
  logic                           mem_broadcast_valid;
  logic                           busy;
  logic                           timeout_err;

  modport slave (
    input  req_valid, req_addr, mem_ready, mem_data, mem_broadcast_addr, mem_broadcast_valid,
    output req_ready, req_data, bcast_addr, bcast_valid, mem_valid, mem_addr, busy, timeout_err
  );

  modport master (
    output req_valid, req_addr, mem_ready, mem_data, mem_broadcast_addr, mem_broadcast_valid,
    input  req_ready, req_data, bcast_addr, bcast_valid, mem_valid, mem_addr, busy, timeout_err
  );
endinterface

// File: rtl/engine_memory_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port between the regex
// engines. One access in flight at a time; engines waiting on the in-flight address
// are answered together with the owner. The memory broadcast is forwarded with one
// cycle of delay, and a sticky watchdog flags an access that never completes.
module engine_memory_arbiter #(
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int ENGINE_ID_BITS    = 2,
  parameter int TIMEOUT_WIDTH     = 8
) (
  input logic                    clk,
  input logic                    rst,
  engine_memory_arbiter_if.slave bus
);
  localparam int N  = 2 ** ENGINE_ID_BITS;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                    state;
  logic [ENGINE_ID_BITS-1:0] rr_ptr;
  logic [ENGINE_ID_BITS-1:0] owner;
  logic [TIMEOUT_WIDTH-1:0]  wd_cnt;

  logic                      grant_found;
  logic [ENGINE_ID_BITS-1:0] grant_id;
  logic [ENGINE_ID_BITS-1:0] scan_idx;
  logic [N-1:0]              match_mask;

  assign bus.busy = (state != IDLE);

  // Pick the first requesting engine at or after rr_ptr, wrapping modulo N.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = rr_ptr + k[ENGINE_ID_BITS-1:0];
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  // Engines to answer: the owner plus every engine waiting on the latched address.
  always_comb begin
    match_mask = '0;
    for (int unsigned j = 0; j < N; j++) begin
      match_mask[j] = bus.req_valid[j] && (bus.req_addr[j*AW +: AW] == bus.mem_addr);
    end
    match_mask[owner] = 1'b1;
  end

  // Request FSM: grant in IDLE, hold the memory request in WAIT, strobe responses in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.req_ready <= '0;
      bus.req_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= '0;
          if (grant_found) begin
            owner         <= grant_id;
            rr_ptr        <= grant_id + ENGINE_ID_BITS'(1);
            bus.mem_addr  <= bus.req_addr[grant_id*AW +: AW];
            bus.mem_valid <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            bus.req_data  <= bus.mem_data;
            bus.req_ready <= match_mask;
            bus.mem_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.req_ready <= '0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Watchdog: count WAIT cycles, saturate, and latch the error until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt          <= '0;
      bus.timeout_err <= 1'b0;
    end else if (state == WAIT) begin
      if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + TIMEOUT_WIDTH'(1);
      end
      if (wd_cnt == WD_MAX - TIMEOUT_WIDTH'(1)) begin
        bus.timeout_err <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end

  // Forward the memory broadcast one cycle later, independent of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.bcast_addr  <= '0;
      bus.bcast_valid <= 1'b0;
    end else begin
      bus.bcast_addr  <= bus.mem_broadcast_addr;
      bus.bcast_valid <= bus.mem_broadcast_valid;
    end
  end
endmodule
